// File: rtl/jtoutrun_obj_pkg.sv
// Shared object-path definitions: pixel word width, blank value and field offsets.
// Used by the draw engine, the line buffer and the mixer.
package jtoutrun_obj_pkg;

    localparam int unsigned OBJ_BW  = 14;
    localparam logic [13:0] OBJ_CLR = 14'h3FFF;

    // {pal[6:0], shadow, prio[1:0], pxl[3:0]}
    localparam int unsigned PAL_MSB    = 13;
    localparam int unsigned SHADOW_BIT = 6;
    localparam int unsigned PRIO_LSB   = 4;
    localparam int unsigned PXL_LSB    = 0;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM with one write-only port and one read/write port.
// Reads return the contents before a same-edge write (read-before-write).
module jtframe_dual_ram #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 14
) (
    input  logic          clk,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    input  logic [DW-1:0] data1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        q1 <= mem[addr1];
        if (we0) mem[addr0] <= data0;
        if (we1) mem[addr1] <= data1;
    end

endmodule

// File: rtl/jtoutrun_obj_lbuf.sv
// Double-buffered object line buffer: the draw engine fills bank[sel] while bank[~sel]
// is read out at pixel rate and cleared behind the read. Banks swap on hstart.
module jtoutrun_obj_lbuf
    import jtoutrun_obj_pkg::*;
#(
    parameter logic [OBJ_BW-1:0] CLR     = OBJ_CLR,
    parameter int unsigned       CEN_MIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pxl_cen,
    input  logic              hstart,
    input  logic              LHBL,
    input  logic [8:0]        hdump,
    input  logic [OBJ_BW-1:0] bf_data,
    input  logic              bf_we,
    input  logic [8:0]        bf_addr,
    output logic [OBJ_BW-1:0] pxl,
    output logic              init
);

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // The RAM output is sampled one clk after hdump settles, so pxl_cen must be sparser.
    if (CEN_MIN < 2) begin : g_cen_min_check
        $error("jtoutrun_obj_lbuf: read path needs CEN_MIN >= 2");
    end

    logic [0:0]        st;
    logic [8:0]        cnt;
    logic              sel;
    logic              flush;
    logic [1:0]        we0, we1;
    logic [8:0]        addr0;
    logic [OBJ_BW-1:0] data0;
    logic [OBJ_BW-1:0] q1 [2];
    logic [OBJ_BW-1:0] rd_q;

    assign flush = (st == ST_FLUSH);
    assign init  = flush;
    assign addr0 = flush ? cnt : bf_addr;
    assign data0 = flush ? CLR : bf_data;
    assign rd_q  = sel ? q1[0] : q1[1];

    // Port 0: flush or draw writes; port 1: continuous read at hdump, clear on pxl_cen.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign we0[b] = flush | (bf_we & (sel == 1'(b)));
        assign we1[b] = ~flush & pxl_cen & (sel != 1'(b));

        jtframe_dual_ram #(
            .AW (9),
            .DW (OBJ_BW)
        ) u_ram (
            .clk   (clk),
            .data0 (data0),
            .addr0 (addr0),
            .we0   (we0[b]),
            .data1 (CLR),
            .addr1 (hdump),
            .we1   (we1[b]),
            .q1    (q1[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= ST_FLUSH;
            cnt <= '0;
            sel <= 1'b0;
            pxl <= CLR;
        end else begin
            case (st)
                ST_FLUSH: begin
                    cnt <= cnt + 9'd1;
                    if (cnt == '1) st <= ST_RUN;
                end
                default: begin
                    if (hstart)  sel <= ~sel;
                    if (pxl_cen) pxl <= LHBL ? rd_q : CLR;
                end
            endcase
        end
    end

endmodule
